// File: rtl/extreme_tracker_if.sv
// extreme_tracker_if: sample input and result readout bundle
// between the sample source and the status register bank.
interface extreme_tracker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              min_mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic              empty;
  logic              ovf;
  logic [DATA_W-1:0] ext_value;
  logic [CNT_W-1:0]  ext_index;
  logic [CNT_W-1:0]  count;

  modport master (
    output start, min_mode, in_valid, in_data,
    input  busy, done, empty, ovf,
    input  ext_value, ext_index, count
  );

  modport slave (
    input  start, min_mode, in_valid, in_data,
    output busy, done, empty, ovf,
    output ext_value, ext_index, count
  );
endinterface

// File: rtl/extreme_tracker.sv
// extreme_tracker: running max/min tracker with sample index,
// sample count, saturation flag and held results.
module extreme_tracker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst,
  extreme_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              run_start;
  logic              accept;
  logic              better;
  logic              mode_q;
  logic              empty_q;
  logic              ovf_q;
  logic [DATA_W-1:0] ext_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and run-start / accept strobes
  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          run_start = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!bus.start)       state_d = DONE;
        else if (bus.in_valid) accept = 1'b1;
      end
      DONE: begin
        if (bus.start) begin
          run_start = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strict compare of the sample against the stored extreme
  always_comb begin
    better = 1'b0;
    if (SIGNED) begin
      if (mode_q) better = $signed(bus.in_data) < $signed(ext_q);
      else        better = $signed(bus.in_data) > $signed(ext_q);
    end else begin
      if (mode_q) better = bus.in_data < ext_q;
      else        better = bus.in_data > ext_q;
    end
  end

  // Result registers: cleared at run start, updated on accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      empty_q <= 1'b0;
      ovf_q   <= 1'b0;
      ext_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (run_start) begin
      mode_q  <= bus.min_mode;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      ext_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (cnt_q == '1) begin
        ovf_q <= 1'b1;
      end else begin
        if (empty_q || better) begin
          ext_q <= bus.in_data;
          idx_q <= cnt_q;
        end
        cnt_q   <= cnt_q + CNT_W'(1);
        empty_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.empty     = empty_q;
  assign bus.ovf       = ovf_q;
  assign bus.ext_value = ext_q;
  assign bus.ext_index = idx_q;
  assign bus.count     = cnt_q;

endmodule

// File: tb/tb_extreme_tracker.sv
// tb_extreme_tracker: three parameterisations driven in lockstep,
// results checked against a queue of expected run outcomes.
module tb_extreme_tracker;

  typedef struct {
    int          inst;
    logic [31:0] val;
    logic [31:0] idx;
    logic [31:0] cnt;
    logic        emp;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic min_mode;
  logic in_valid;
  logic [7:0] in_data;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  extreme_tracker_if #(.DATA_W(8), .CNT_W(8)) if_a ();
  extreme_tracker_if #(.DATA_W(8), .CNT_W(8)) if_b ();
  extreme_tracker_if #(.DATA_W(8), .CNT_W(3)) if_c ();

  assign if_a.start = start;
  assign if_b.start = start;
  assign if_c.start = start;
  assign if_a.min_mode = min_mode;
  assign if_b.min_mode = min_mode;
  assign if_c.min_mode = min_mode;
  assign if_a.in_valid = in_valid;
  assign if_b.in_valid = in_valid;
  assign if_c.in_valid = in_valid;
  assign if_a.in_data = in_data;
  assign if_b.in_data = in_data;
  assign if_c.in_data = in_data;

  extreme_tracker #(.DATA_W(8), .CNT_W(8), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  extreme_tracker #(.DATA_W(8), .CNT_W(8), .SIGNED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );
  extreme_tracker #(.DATA_W(8), .CNT_W(3), .SIGNED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input int inst,
                      output logic [31:0] v, output logic [31:0] i,
                      output logic [31:0] c, output logic e,
                      output logic o, output logic d, output logic b);
    case (inst)
      0: begin
        v = 32'(if_a.ext_value); i = 32'(if_a.ext_index);
        c = 32'(if_a.count); e = if_a.empty; o = if_a.ovf;
        d = if_a.done; b = if_a.busy;
      end
      1: begin
        v = 32'(if_b.ext_value); i = 32'(if_b.ext_index);
        c = 32'(if_b.count); e = if_b.empty; o = if_b.ovf;
        d = if_b.done; b = if_b.busy;
      end
      default: begin
        v = 32'(if_c.ext_value); i = 32'(if_c.ext_index);
        c = 32'(if_c.count); e = if_c.empty; o = if_c.ovf;
        d = if_c.done; b = if_c.busy;
      end
    endcase
  endtask

  task automatic push(input int inst, input logic [31:0] v,
                      input logic [31:0] i, input logic [31:0] c,
                      input logic e, input logic o);
    exp_t x;
    x.inst = inst; x.val = v; x.idx = i;
    x.cnt = c; x.emp = e; x.ovf = o;
    sb.push_back(x);
  endtask

  task automatic push_all(input logic [31:0] v, input logic [31:0] i,
                          input logic [31:0] c, input logic e);
    for (int k = 0; k < 3; k++) push(k, v, i, c, e, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] v, i, c;
    logic e, o, d, b;
    for (int k = 0; k < 3; k++) begin
      peek(k, v, i, c, e, o, d, b);
      chk($sformatf("%s_%0d_val", tag, k), v, 0);
      chk($sformatf("%s_%0d_idx", tag, k), i, 0);
      chk($sformatf("%s_%0d_cnt", tag, k), c, 0);
      chk($sformatf("%s_%0d_flags", tag, k),
          {28'd0, e, o, d, b}, 0);
    end
  endtask

  task automatic begin_run(input logic mm);
    @(negedge clk);
    start = 1'b1; min_mode = mm; in_valid = 1'b0;
  endtask

  task automatic sample(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic end_run(input string tag);
    logic [31:0] v, i, c;
    logic e, o, d, b;
    exp_t x;
    int n;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hFE;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!if_a.done && n < 4);
    in_valid = 1'b0;
    chk({tag, "_done"}, 32'(if_a.done), 1);
    for (int k = 0; k < 3; k++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_underflow"}, 0, 1);
      end else begin
        x = sb.pop_front();
        peek(x.inst, v, i, c, e, o, d, b);
        chk($sformatf("%s_%0d_val", tag, x.inst), v, x.val);
        chk($sformatf("%s_%0d_idx", tag, x.inst), i, x.idx);
        chk($sformatf("%s_%0d_cnt", tag, x.inst), c, x.cnt);
        chk($sformatf("%s_%0d_empty", tag, x.inst), 32'(e), 32'(x.emp));
        chk($sformatf("%s_%0d_ovf", tag, x.inst), 32'(o), 32'(x.ovf));
        chk($sformatf("%s_%0d_dn_bsy", tag, x.inst), {30'd0, d, b}, 2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; min_mode = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // reset mid-run after three accepts
    begin_run(1'b0);
    sample(8'd4);
    sample(8'd6);
    sample(8'd2);
    @(posedge clk); #1;
    chk("mid_busy", 32'(if_a.busy), 1);
    chk("mid_cnt", 32'(if_a.count), 3);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    begin_run(1'b0);
    sample(8'd3);
    sample(8'd7);
    push_all(7, 1, 2, 1'b0);
    end_run("after_rst");

    // max, unsigned; tie keeps earliest index
    begin_run(1'b0);
    sample(8'd5);
    sample(8'd9);
    sample(8'd9);
    sample(8'd3);
    push_all(9, 1, 4, 1'b0);
    end_run("max");

    // min with mode toggled mid-run
    begin_run(1'b1);
    sample(8'h10);
    sample(8'hF0);
    min_mode = 1'b0;
    sample(8'h80);
    sample(8'h7F);
    push(0, 32'h10, 0, 4, 1'b0, 1'b0);
    push(1, 32'h80, 2, 4, 1'b0, 1'b0);
    push(2, 32'h10, 0, 4, 1'b0, 1'b0);
    end_run("min");

    // empty run with gaps, then minimum one-cycle run
    begin_run(1'b0);
    gap();
    gap();
    gap();
    push_all(0, 0, 0, 1'b1);
    end_run("empty4");
    begin_run(1'b0);
    push_all(0, 0, 0, 1'b1);
    end_run("empty1");

    // counter saturation on the 3-bit instance
    begin_run(1'b0);
    for (int k = 1; k <= 8; k++) sample(8'(k));
    sample(8'd200);
    push(0, 200, 8, 9, 1'b0, 1'b0);
    push(1, 8, 7, 9, 1'b0, 1'b0);
    push(2, 7, 6, 7, 1'b0, 1'b1);
    end_run("sat");

    // restart straight from DONE; same-cycle sample is not taken
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    @(posedge clk); #1;
    chk("rs_done", 32'(if_a.done), 0);
    chk("rs_busy", 32'(if_a.busy), 1);
    chk("rs_cnt", 32'(if_a.count), 0);
    chk("rs_val", 32'(if_a.ext_value), 0);
    chk("rs_empty", 32'(if_a.empty), 1);
    chk("rs_ovf_c", 32'(if_c.ovf), 0);
    sample(8'd42);
    sample(8'd17);
    push_all(42, 0, 2, 1'b0);
    end_run("restart");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
